// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared fetch types and constants for the instruction prefetch path
package mycpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RECV  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;
   localparam int          BURST_LEN        = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; head entry read straight from storage
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - burst prefetcher with PC tagging, credit check and redirect flush
module inst_fetch_buffer
   import mycpu_pkg::*;
#(
   parameter int          DEPTH       = 8,
   parameter int          BURST_BEATS = BURST_LEN,
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        inst_sram_req,
   output logic [2:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_rdy,
   input  logic        inst_sram_valid,
   input  logic        inst_sram_last,
   input  logic [31:0] inst_sram_rdata
);

   localparam int          CW          = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] BURST_C   = CW'(BURST_BEATS);
   localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_BEATS);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  recv_pc_q, recv_pc_d;
   logic         discard_q, discard_d;
   logic         req_q, req_d;
   logic [31:0]  addr_q, addr_d;

   logic         push, pop;
   logic [CW-1:0] count;
   fetch_entry_t push_entry, head_entry;

   assign push_entry = '{pc: recv_pc_q, inst: inst_sram_rdata};
   assign out_valid  = (count != '0);
   assign pop        = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      recv_pc_d  = recv_pc_q;
      discard_d  = discard_q;
      push       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Credit: only ask for a burst that is guaranteed room for every beat.
            if (!redirect_valid && (DEPTH_C - count) >= BURST_C) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (inst_sram_rdy) begin
               if (discard_q || redirect_valid) begin
                  state_d   = ST_DRAIN;
                  discard_d = 1'b0;
               end else begin
                  state_d    = ST_RECV;
                  recv_pc_d  = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + BURST_BYTES;
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         ST_RECV: begin
            if (redirect_valid) begin
               state_d = (inst_sram_valid && inst_sram_last) ? ST_IDLE : ST_DRAIN;
            end else if (inst_sram_valid) begin
               push      = 1'b1;
               recv_pc_d = recv_pc_q + 32'd4;
               if (inst_sram_last) state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (inst_sram_valid && inst_sram_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (redirect_valid) fetch_pc_d = redirect_pc & ~32'd3;
   end

   // Request is held with its original address until accepted, even across a redirect.
   always_comb begin
      req_d  = (state_d == ST_REQ);
      addr_d = addr_q;
      if (state_q != ST_REQ && state_d == ST_REQ) addr_d = fetch_pc_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         recv_pc_q  <= '0;
         discard_q  <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         recv_pc_q  <= recv_pc_d;
         discard_q  <= discard_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head_data (head_entry)
   );

   assign out_pc         = out_valid ? head_entry.pc   : '0;
   assign out_inst       = out_valid ? head_entry.inst : '0;
   assign inst_sram_req  = req_q;
   assign inst_sram_addr = addr_q;
   assign inst_sram_size = 3'(BURST_BEATS - 1);

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - directed vector bench for inst_fetch_buffer
module tb_inst_fetch_buffer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        inst_sram_req;
   logic [2:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_rdy;
   logic        inst_sram_valid;
   logic        inst_sram_last;
   logic [31:0] inst_sram_rdata;

   always #5 clk = ~clk;

   inst_fetch_buffer dut (
      .clk             (clk),
      .resetn          (resetn),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .inst_sram_req   (inst_sram_req),
      .inst_sram_size  (inst_sram_size),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdy   (inst_sram_rdy),
      .inst_sram_valid (inst_sram_valid),
      .inst_sram_last  (inst_sram_last),
      .inst_sram_rdata (inst_sram_rdata)
   );

   typedef struct {
      logic        rdy;
      logic        vld;
      logic        lst;
      logic [31:0] beat_pc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_ov;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vt[8];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic ov, input logic [31:0] pc);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, ".out_pc"}, out_pc, ov ? pc : 32'd0);
      chk({tag, ".out_inst"}, out_inst, ov ? ~pc : 32'd0);
   endtask

   task automatic chk_req(input string tag, input logic rq, input logic [31:0] addr);
      chk({tag, ".req"}, 32'(inst_sram_req), 32'(rq));
      chk({tag, ".addr"}, inst_sram_addr, addr);
   endtask

   task automatic beat(input logic [31:0] pc, input logic lst);
      inst_sram_valid = 1'b1;
      inst_sram_last  = lst;
      inst_sram_rdata = ~pc;
   endtask

   task automatic serve_burst(input logic [31:0] pc0);
      inst_sram_rdy = 1'b1;
      step();
      inst_sram_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat(pc0 + 32'(4 * i), i == 3);
         step();
      end
      inst_sram_valid = 1'b0;
      inst_sram_last  = 1'b0;
   endtask

   initial begin
      int   rises;
      logic prev;
      vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
      vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_0000, 1'b0, 32'h0};
      vt[2] = '{1'b0, 1'b1, 1'b0, 32'hbfc0_0000, 1'b0, 32'hbfc0_0000, 1'b0, 32'h0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 32'hbfc0_0004, 1'b0, 32'hbfc0_0000, 1'b1, 32'hbfc0_0000};
      vt[4] = '{1'b0, 1'b1, 1'b0, 32'hbfc0_0008, 1'b0, 32'hbfc0_0000, 1'b1, 32'hbfc0_0004};
      vt[5] = '{1'b0, 1'b1, 1'b1, 32'hbfc0_000c, 1'b0, 32'hbfc0_0000, 1'b1, 32'hbfc0_0008};
      vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'hbfc0_0000, 1'b1, 32'hbfc0_000c};
      vt[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_0010, 1'b0, 32'h0};

      resetn          = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      out_ready       = 1'b1;
      inst_sram_rdy   = 1'b0;
      inst_sram_valid = 1'b0;
      inst_sram_last  = 1'b0;
      inst_sram_rdata = '0;
      repeat (3) step();
      chk_out("reset", 1'b0, 32'h0);
      chk_req("reset", 1'b0, 32'h0);
      chk("reset.size", 32'(inst_sram_size), 32'd3);

      // Reset fetch: one burst from the reset vector, drained as it arrives.
      resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         inst_sram_rdy   = vt[i].rdy;
         inst_sram_valid = vt[i].vld;
         inst_sram_last  = vt[i].lst;
         inst_sram_rdata = ~vt[i].beat_pc;
         chk_req($sformatf("vec%0d", i), vt[i].exp_req, vt[i].exp_addr);
         chk_out($sformatf("vec%0d", i), vt[i].exp_ov, vt[i].exp_pc);
         step();
      end

      // Backpressure: two bursts fill the queue, no third request until room frees.
      out_ready = 1'b0;
      serve_burst(32'hbfc0_0010);
      chk_out("bp.head1", 1'b1, 32'hbfc0_0010);
      step();
      chk_req("bp.req2", 1'b1, 32'hbfc0_0020);
      serve_burst(32'hbfc0_0020);
      rises = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (inst_sram_req) rises++;
      end
      chk("bp.full_no_req", 32'(rises), 32'd0);
      chk_out("bp.head_stable", 1'b1, 32'hbfc0_0010);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("bp.pop%0d", i), 1'b1, 32'hbfc0_0010 + 32'(4 * i));
         step();
      end
      out_ready = 1'b0;
      rises = 0;
      prev  = inst_sram_req;
      for (int i = 0; i < 6; i++) begin
         step();
         if (inst_sram_req && !prev) rises++;
         prev = inst_sram_req;
      end
      chk("bp.one_req", 32'(rises), 32'd1);
      chk_req("bp.req3", 1'b1, 32'hbfc0_0030);
      chk_out("bp.head2", 1'b1, 32'hbfc0_0020);

      // Redirect after beat 1 of a burst.
      inst_sram_rdy = 1'b1;
      step();
      inst_sram_rdy = 1'b0;
      beat(32'hbfc0_0030, 1'b0);
      step();
      beat(32'hbfc0_0034, 1'b0);
      step();
      beat(32'hbfc0_0038, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_1234;
      step();
      redirect_valid = 1'b0;
      chk_out("mid.flushed", 1'b0, 32'h0);
      beat(32'hbfc0_003c, 1'b1);
      step();
      inst_sram_valid = 1'b0;
      inst_sram_last  = 1'b0;
      chk_out("mid.dropped", 1'b0, 32'h0);
      chk("mid.idle_req", 32'(inst_sram_req), 32'd0);
      step();
      chk_req("mid.req", 1'b1, 32'h8000_1234);
      serve_burst(32'h8000_1234);
      chk_out("mid.first", 1'b1, 32'h8000_1234);
      step();
      chk_req("mid.next", 1'b1, 32'h8000_1244);

      // Redirect while the request waits for rdy; low address bits ignored.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h9000_0103;
      step();
      redirect_valid = 1'b0;
      chk_out("reqlo.flushed", 1'b0, 32'h0);
      chk_req("reqlo.held", 1'b1, 32'h8000_1244);
      step();
      step();
      chk_req("reqlo.held2", 1'b1, 32'h8000_1244);
      serve_burst(32'h8000_1244);
      chk_out("reqlo.dropped", 1'b0, 32'h0);
      chk("reqlo.idle_req", 32'(inst_sram_req), 32'd0);
      step();
      chk_req("reqlo.req", 1'b1, 32'h9000_0100);
      serve_burst(32'h9000_0100);
      chk_out("reqlo.first", 1'b1, 32'h9000_0100);

      // Redirect in the same cycle as the last beat.
      step();
      chk_req("last.req", 1'b1, 32'h9000_0110);
      inst_sram_rdy = 1'b1;
      step();
      inst_sram_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat(32'h9000_0110 + 32'(4 * i), 1'b0);
         step();
      end
      beat(32'h9000_011c, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'ha000_0000;
      step();
      redirect_valid  = 1'b0;
      inst_sram_valid = 1'b0;
      inst_sram_last  = 1'b0;
      chk_out("last.flushed", 1'b0, 32'h0);
      chk("last.idle_req", 32'(inst_sram_req), 32'd0);
      step();
      chk_req("last.req_t2", 1'b1, 32'ha000_0000);

      // Synchronous reset in the middle of a burst.
      inst_sram_rdy = 1'b1;
      step();
      inst_sram_rdy = 1'b0;
      beat(32'ha000_0000, 1'b0);
      step();
      chk_out("rst.before", 1'b1, 32'ha000_0000);
      resetn = 1'b0;
      beat(32'ha000_0004, 1'b0);
      step();
      resetn          = 1'b1;
      inst_sram_valid = 1'b0;
      chk_out("rst.after", 1'b0, 32'h0);
      chk_req("rst.after", 1'b0, 32'h0);
      step();
      chk_req("rst.refetch", 1'b1, 32'hbfc0_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
